register_unit_sequencer: RTL and testbench

- Multi-cycle controller that fetches 8-bit instructions and sequences the 4x8-bit, 2-read/1-write register file to execute them.
- Sits between the instruction memory (req/ack handshake) and the register file.
- Drives both read addresses, the write port and the PC. Contains its own 8-bit adder/subtractor.

---
 rtl/register_unit_sequencer.sv | 174 +++++++++++++++++
 tb/tb_register_unit_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_unit_sequencer.sv
// register_unit_sequencer: fetch/decode/exec/writeback controller for a 4x8-bit, 2R/1W register file.
// Latency: ALU op 4 cycles, JMP 3 cycles from FETCH entry; each imem_ack wait cycle adds 1.
// Backpressure: FETCH holds imem_req/imem_addr until imem_ack; start is ignored while busy.
// Optional feature macro: SEQ_OVF_FLAG_EN adds a sticky signed-overflow output ovf.
module register_unit_sequencer #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] START_PC = '0
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            start,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [7:0]      imem_data,
   output logic [1:0]      rf_raddr1,
   output logic [1:0]      rf_raddr2,
   input  logic [7:0]      rf_rdata1,
   input  logic [7:0]      rf_rdata2,
   output logic            rf_we,
   output logic [1:0]      rf_waddr,
   output logic [7:0]      rf_wdata,
   output logic [PC_W-1:0] pc,
   output logic            busy,
   output logic            halted
`ifdef SEQ_OVF_FLAG_EN
   ,
   output logic            ovf
`endif
);

   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} seqState_t;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_ADDI = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_JMP  = 2'b11;

   seqState_t       stateQ, stateD;
   logic [PC_W-1:0] pcQ, pcD;
   logic [7:0]      instrQ, instrD;
   logic [7:0]      resultQ, resultD;
   logic            startAcc;

   logic [1:0]      opcode;
   logic [7:0]      aluB;
   logic [7:0]      aluSum;
   logic [PC_W-1:0] jmpTarget;

   assign opcode = instrQ[7:6];
   assign pc     = pcQ;

   // ALU: second operand is rt for ADD/SUB, sign-extended imm2 for ADDI; JMP target is pc + sext(imm6)
   always_comb begin
      aluB      = (opcode == OP_ADDI) ? {{6{instrQ[1]}}, instrQ[1:0]} : rf_rdata2;
      aluSum    = (opcode == OP_SUB) ? (rf_rdata1 - aluB) : (rf_rdata1 + aluB);
      jmpTarget = pcQ + {{(PC_W-6){instrQ[5]}}, instrQ[5:0]};
   end

   // Next-state and output decode; every output idles at zero outside its owning state
   always_comb begin
      stateD    = stateQ;
      pcD       = pcQ;
      instrD    = instrQ;
      resultD   = resultQ;
      startAcc  = 1'b0;
      imem_req  = 1'b0;
      imem_addr = '0;
      rf_raddr1 = 2'd0;
      rf_raddr2 = 2'd0;
      rf_we     = 1'b0;
      rf_waddr  = 2'd0;
      rf_wdata  = 8'd0;
      busy      = 1'b0;
      halted    = 1'b0;
      case (stateQ)
         IDLE, HALT: begin
            halted = (stateQ == HALT);
            if (start) begin
               startAcc = 1'b1;
               pcD      = START_PC;
               stateD   = FETCH;
            end
         end
         FETCH: begin
            busy      = 1'b1;
            imem_req  = 1'b1;
            imem_addr = pcQ;
            if (imem_ack) begin
               instrD = imem_data;
               stateD = DECODE;
            end
         end
         DECODE: begin
            busy      = 1'b1;
            rf_raddr1 = instrQ[5:4];
            rf_raddr2 = instrQ[3:2];
            stateD    = EXEC;
         end
         EXEC: begin
            busy      = 1'b1;
            rf_raddr1 = instrQ[5:4];
            rf_raddr2 = instrQ[3:2];
            if (opcode == OP_JMP) begin
               if (instrQ[5:0] == 6'd0) begin
                  stateD = HALT;
               end else begin
                  pcD    = jmpTarget;
                  stateD = FETCH;
               end
            end else begin
               resultD = aluSum;
               stateD  = WB;
            end
         end
         WB: begin
            busy     = 1'b1;
            rf_we    = 1'b1;
            rf_waddr = (opcode == OP_ADDI) ? instrQ[3:2] : instrQ[1:0];
            rf_wdata = resultQ;
            pcD      = pcQ + PC_W'(1);
            stateD   = FETCH;
         end
         default: stateD = IDLE;
      endcase
   end

   // State, PC, instruction and result registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         stateQ  <= IDLE;
         pcQ     <= START_PC;
         instrQ  <= 8'd0;
         resultQ <= 8'd0;
      end else begin
         stateQ  <= stateD;
         pcQ     <= pcD;
         instrQ  <= instrD;
         resultQ <= resultD;
      end
   end

`ifdef SEQ_OVF_FLAG_EN
   logic aluOvf;
   logic aluOvfQ;
   logic ovfQ;

   // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the result sign flips
   always_comb begin
      if (opcode == OP_SUB)
         aluOvf = (rf_rdata1[7] != aluB[7]) && (aluSum[7] != rf_rdata1[7]);
      else
         aluOvf = (rf_rdata1[7] == aluB[7]) && (aluSum[7] != rf_rdata1[7]);
   end

   // Overflow travels with the result and sets the sticky flag when that result is written
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         aluOvfQ <= 1'b0;
         ovfQ    <= 1'b0;
      end else begin
         if (stateQ == EXEC)
            aluOvfQ <= aluOvf && (opcode != OP_JMP);
         if (startAcc)
            ovfQ <= 1'b0;
         else if (stateQ == WB && aluOvfQ)
            ovfQ <= 1'b1;
      end
   end

   assign ovf = ovfQ;
`endif

endmodule

// File: tb/tb_register_unit_sequencer.sv
// tb_register_unit_sequencer: randomized + directed bench with an instruction-level reference model.
// Latency: the model predicts outputs per cycle from ack timing and instruction kind.
// Backpressure: the instruction memory responder inserts configurable or random ack waits.
module tb_register_unit_sequencer;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       start = 1'b0;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic       imem_ack = 1'b0;
   logic [7:0] imem_data = 8'd0;
   logic [1:0] rf_raddr1, rf_raddr2;
   logic [7:0] rf_rdata1, rf_rdata2;
   logic       rf_we;
   logic [1:0] rf_waddr;
   logic [7:0] rf_wdata;
   logic [7:0] pc;
   logic       busy, halted;
`ifdef SEQ_OVF_FLAG_EN
   logic       ovf;
`endif

   register_unit_sequencer #(.PC_W(8), .START_PC(8'h00)) dut (
      .CLK(CLK), .RST_N(RST_N), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .pc(pc), .busy(busy), .halted(halted)
`ifdef SEQ_OVF_FLAG_EN
      , .ovf(ovf)
`endif
   );

   always #5 CLK = ~CLK;

   int nChecks = 0;
   int nPass   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp)
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      else
         nPass++;
   endtask

   // Environment: register file and instruction memory
   logic [7:0] rf[4];
   logic [7:0] imem[256];
   assign rf_rdata1 = rf[rf_raddr1];
   assign rf_rdata2 = rf[rf_raddr2];

   always @(posedge CLK) begin
      if (rf_we) rf[rf_waddr] = rf_wdata;
   end

   // Instruction memory responder: answers a request after ackWaitCfg cycles (-1 = random 0..3)
   int ackWaitCfg = 0;
   bit noiseEn    = 1'b0;
   int waitLeft   = -1;
   always @(negedge CLK) begin
      #1;
      if (imem_req === 1'b1) begin
         if (waitLeft < 0) waitLeft = (ackWaitCfg < 0) ? int'($urandom_range(0, 3)) : ackWaitCfg;
         if (waitLeft == 0) begin
            imem_ack  = 1'b1;
            imem_data = imem[imem_addr];
            waitLeft  = -1;
         end else begin
            imem_ack  = 1'b0;
            imem_data = 8'($urandom);
            waitLeft--;
         end
      end else begin
         waitLeft  = -1;
         imem_ack  = noiseEn ? 1'($urandom) : 1'b0;
         imem_data = 8'($urandom);
      end
   end

   // Reference model: instruction-level architectural state plus the cycle offset since fetch ack
   bit         modelOk = 1'b0;
   bit         mFetch, mHalted, mIsAlu, mOvfPend, mOvf;
   int         mPhase;
   logic [7:0] mPc, mInstr, mWData;
   logic [1:0] mWAddr;
   logic [7:0] mReg[4];

   function automatic int sx8(input logic [7:0] v);
      return v[7] ? int'(v) - 256 : int'(v);
   endfunction

   always @(posedge CLK) begin : model
      int sa, sb, sum, imm;
      if (!RST_N) begin
         if (modelOk && mPhase == 3) mReg[mWAddr] = mWData;
         mFetch = 0; mPhase = 0; mHalted = 0; mIsAlu = 0; mOvfPend = 0; mOvf = 0;
         mPc = 8'h00; mInstr = 8'h00; mWData = 8'h00; mWAddr = 2'd0;
         modelOk = 1'b1;
      end else if (modelOk) begin
         if (mFetch) begin
            if (imem_ack) begin
               mInstr = imem_data;
               mFetch = 0;
               mPhase = 1;
               sa = sx8(mReg[imem_data[5:4]]);
               sb = sx8(mReg[imem_data[3:2]]);
               case (imem_data[7:6])
                  2'b00: begin sum = sa + sb; mWAddr = imem_data[1:0]; end
                  2'b01: begin
                     imm = imem_data[1] ? int'(imem_data[1:0]) - 4 : int'(imem_data[1:0]);
                     sum = sa + imm; mWAddr = imem_data[3:2];
                  end
                  2'b10: begin sum = sa - sb; mWAddr = imem_data[1:0]; end
                  default: begin sum = 0; mWAddr = 2'd0; end
               endcase
               mIsAlu   = (imem_data[7:6] != 2'b11);
               mWData   = 8'(sum);
               mOvfPend = mIsAlu && (sum > 127 || sum < -128);
            end
         end else if (mPhase > 0) begin
            mPhase++;
            if (mPhase == 3 && !mIsAlu) begin
               imm = mInstr[5] ? int'(mInstr[5:0]) - 64 : int'(mInstr[5:0]);
               if (imm == 0) mHalted = 1;
               else begin mPc = 8'(int'(mPc) + imm); mFetch = 1; end
               mPhase = 0;
            end else if (mPhase == 4) begin
               mReg[mWAddr] = mWData;
               if (mOvfPend) mOvf = 1;
               mPc = mPc + 8'd1;
               mPhase = 0;
               mFetch = 1;
            end
         end else if (start) begin
            mPc = 8'h00; mFetch = 1; mHalted = 0; mOvf = 0;
         end
      end
   end

   // Compare process: every cycle after the first reset, all outputs against the model
   always @(negedge CLK) begin : cmp
      bit eBusy, eWe, eRd;
      if (modelOk) begin
         eBusy = mFetch || mPhase > 0;
         eWe   = (mPhase == 3);
         eRd   = (mPhase == 1 || mPhase == 2);
         check("busy",      32'(busy),      32'(eBusy));
         check("halted",    32'(halted),    32'(mHalted));
         check("pc",        32'(pc),        32'(mPc));
         check("imem_req",  32'(imem_req),  32'(mFetch));
         check("imem_addr", 32'(imem_addr), mFetch ? 32'(mPc) : 32'd0);
         check("rf_raddr1", 32'(rf_raddr1), eRd ? 32'(mInstr[5:4]) : 32'd0);
         check("rf_raddr2", 32'(rf_raddr2), eRd ? 32'(mInstr[3:2]) : 32'd0);
         check("rf_we",     32'(rf_we),     32'(eWe));
         check("rf_waddr",  32'(rf_waddr),  eWe ? 32'(mWAddr) : 32'd0);
         check("rf_wdata",  32'(rf_wdata),  eWe ? 32'(mWData) : 32'd0);
`ifdef SEQ_OVF_FLAG_EN
         check("ovf",       32'(ovf),       32'(mOvf));
`endif
      end
   end

   int cyc;
   task automatic step();
      @(negedge CLK);
      #1;
      cyc++;
   endtask
   task automatic stepTo(input int k);
      while (cyc < k) step();
   endtask
   task automatic setReg(input int i, input logic [7:0] v);
      rf[i] = v;
      mReg[i] = v;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) setReg(i, 8'h00);
      for (int i = 0; i < 256; i++) imem[i] = 8'hC0;
      // Program: ADDI r1,r0,+1; ADD r2,r1,r1; JMP +3; SUB r3,r0,r1; HALT; JMP -2
      imem[0] = 8'h45; imem[1] = 8'h16; imem[2] = 8'hC3;
      imem[3] = 8'h87; imem[4] = 8'hC0; imem[5] = 8'hFE;

      cyc = 0;
      RST_N = 1'b0; step(); step(); RST_N = 1'b1; step();
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_pc",   32'(pc),   32'h00);
      check("reset_req",  32'(imem_req), 32'd0);

      // Reset while a fetch is outstanding
      ackWaitCfg = 20;
      start = 1'b1; step(); start = 1'b0; step();
      check("midfetch_req_before", 32'(imem_req), 32'd1);
      RST_N = 1'b0; step(); RST_N = 1'b1;
      check("midfetch_req", 32'(imem_req), 32'd0);
      check("midfetch_pc",  32'(pc),       32'h00);
      check("midfetch_busy",32'(busy),     32'd0);
      check("midfetch_we",  32'(rf_we),    32'd0);

      // Zero-wait program run, with a start pulse during EXEC
      ackWaitCfg = 0;
      cyc = 0; start = 1'b1; stepTo(1); start = 1'b0;
      check("p1_fetch_pc", 32'(pc), 32'h00);
      stepTo(3); start = 1'b1; stepTo(4); start = 1'b0;
      check("p1_we4",    32'(rf_we),    32'd1);
      check("p1_waddr4", 32'(rf_waddr), 32'd1);
      check("p1_wdata4", 32'(rf_wdata), 32'h01);
      stepTo(8);
      check("p1_we8",    32'(rf_we),    32'd1);
      check("p1_waddr8", 32'(rf_waddr), 32'd2);
      check("p1_wdata8", 32'(rf_wdata), 32'h02);
      stepTo(9);
      check("p1_pc9", 32'(pc), 32'h02);
      stepTo(12);
      check("p1_jmp_pc", 32'(pc), 32'h05);
      stepTo(15);
      check("p1_jmpback_pc", 32'(pc), 32'h03);
      stepTo(18);
      check("p1_sub_waddr", 32'(rf_waddr), 32'd3);
      check("p1_sub_wdata", 32'(rf_wdata), 32'hFF);
      stepTo(22);
      check("p1_halted", 32'(halted), 32'd1);
      check("p1_hbusy",  32'(busy),   32'd0);
      check("p1_hpc",    32'(pc),     32'h04);

      // Three ack wait cycles: request held, write lands at cycle 7
      ackWaitCfg = 3;
      cyc = 0; start = 1'b1; stepTo(1); start = 1'b0;
      check("wait_pc_restart", 32'(pc), 32'h00);
      stepTo(4);
      check("wait_req4",  32'(imem_req),  32'd1);
      check("wait_addr4", 32'(imem_addr), 32'h00);
      stepTo(6);
      check("wait_we6", 32'(rf_we), 32'd0);
      stepTo(7);
      check("wait_we7",    32'(rf_we),    32'd1);
      check("wait_wdata7", 32'(rf_wdata), 32'h01);
      ackWaitCfg = -1; noiseEn = 1'b1;
      cyc = 0;
      while (halted !== 1'b1 && cyc < 300) step();
      check("wait_reach_halt", 32'(halted), 32'd1);

      // PC wrap: JMP -1 at 00 -> FF, ADDI at FF -> 00
      ackWaitCfg = 0; noiseEn = 1'b0;
      imem[0] = 8'hFF; imem[255] = 8'h45;
      cyc = 0; start = 1'b1; stepTo(1); start = 1'b0;
      stepTo(4);
      check("wrap_pc_ff", 32'(pc), 32'hFF);
      stepTo(8);
      check("wrap_pc_00", 32'(pc), 32'h00);
      RST_N = 1'b0; step(); RST_N = 1'b1; step();

`ifdef SEQ_OVF_FLAG_EN
      // ADD r2,r1,r0 with 7F + 01 overflows to 80
      setReg(0, 8'h01); setReg(1, 8'h7F);
      imem[0] = 8'h12; imem[1] = 8'hC0;
      cyc = 0; start = 1'b1; stepTo(1); start = 1'b0;
      stepTo(4);
      check("ovf_wdata", 32'(rf_wdata), 32'h80);
      stepTo(5);
      check("ovf_set", 32'(ovf), 32'd1);
      stepTo(8);
      check("ovf_sticky", 32'(ovf), 32'd1);
      cyc = 0; start = 1'b1; stepTo(1); start = 1'b0;
      check("ovf_clear_on_start", 32'(ovf), 32'd0);
      RST_N = 1'b0; step(); RST_N = 1'b1; step();
`endif

      // Randomized programs, start noise, ack noise and occasional resets
      for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) setReg(i, 8'($urandom));
      ackWaitCfg = -1; noiseEn = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         start = ($urandom_range(0, 3) == 0);
         RST_N = ($urandom_range(0, 249) != 0);
         step();
      end
      RST_N = 1'b1; start = 1'b0;
      step();

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
